// File: rtl/my_tx_sched.sv
// Timed-transmit scheduler: strips a {BEEF, send_time} prefix and holds the packet until master_time.
// Optional late_count counter and its clear register: define TX_SCHED_LATE_COUNT_EN.
module my_tx_sched #(
    parameter logic [7:0]  SR_BASE  = 8'd136,
    parameter logic [31:0] MAX_WAIT = 32'h7FFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] master_time,
    input  logic [31:0] rd_dat_i,
    input  logic [3:0]  rd_flags_i,
    input  logic        rd_ready_i,
    output logic        rd_ready_o,
    output logic [31:0] tx_dat_o,
    output logic [3:0]  tx_flags_o,
    output logic        tx_ready_o,
    input  logic        tx_ready_i,
    output logic        late,
    output logic [15:0] late_count,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WAIT,
        S_PASS,
        S_DROP
    } state_t;

    state_t      state;
    state_t      next;
    logic        enable;
    logic        late_drop;
    logic        imm;
    logic        first;
    logic [31:0] send_time;
    logic [31:0] d;
    logic        late_c;
    logic        eop;
    logic        is_hdr;
    logic        unused_ok;

    assign eop       = rd_flags_i[1];
    assign is_hdr    = enable && (rd_dat_i[31:16] == 16'hBEEF);
    assign d         = send_time - master_time;
    assign tx_dat_o  = rd_dat_i;
    assign tx_flags_o = rd_flags_i;
    assign busy      = (state != S_IDLE);
    assign unused_ok = ^set_data[31:2];

    // Next-state, handshake steering and late detection
    always_comb begin
        next       = state;
        rd_ready_o = 1'b0;
        tx_ready_o = 1'b0;
        late_c     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (is_hdr) begin
                    rd_ready_o = 1'b1;
                    if (rd_ready_i)
                        next = eop ? S_IDLE : S_HDR;
                end else begin
                    tx_ready_o = rd_ready_i;
                    rd_ready_o = tx_ready_i;
                    if (rd_ready_i && tx_ready_i && !eop)
                        next = S_PASS;
                end
            end
            S_HDR: begin
                rd_ready_o = 1'b1;
                if (rd_ready_i)
                    next = eop ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                late_c = first && !imm && (d[31] || d > MAX_WAIT)
                         && (d != 32'd0);
                if (late_c)
                    next = late_drop ? S_DROP : S_PASS;
                else if (imm || d == 32'd0 || d[31])
                    next = S_PASS;
            end
            S_PASS: begin
                tx_ready_o = rd_ready_i;
                rd_ready_o = tx_ready_i;
                if (rd_ready_i && tx_ready_i && eop)
                    next = S_IDLE;
            end
            S_DROP: begin
                rd_ready_o = 1'b1;
                if (rd_ready_i && eop)
                    next = S_IDLE;
            end
            default: next = S_IDLE;
        endcase
        // Handshakes are combinational paths; force them quiet during reset
        if (rst) begin
            rd_ready_o = 1'b0;
            tx_ready_o = 1'b0;
        end
    end

    // State, prefix capture and late pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            imm       <= 1'b0;
            first     <= 1'b0;
            send_time <= 32'd0;
            late      <= 1'b0;
        end else begin
            state <= next;
            first <= (state == S_HDR);
            late  <= late_c;
            if (state == S_IDLE && is_hdr && rd_ready_i)
                imm <= rd_dat_i[0];
            if (state == S_HDR && rd_ready_i)
                send_time <= rd_dat_i;
        end
    end

    // Control register at SR_BASE+0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable    <= 1'b0;
            late_drop <= 1'b0;
        end else if (set_stb && set_addr == SR_BASE) begin
            enable    <= set_data[0];
            late_drop <= set_data[1];
        end
    end

`ifdef TX_SCHED_LATE_COUNT_EN
    // Saturating late counter; a clear write wins over a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            late_count <= 16'd0;
        else if (set_stb && set_addr == SR_BASE + 8'd1)
            late_count <= 16'd0;
        else if (late_c && late_count != 16'hFFFF)
            late_count <= late_count + 16'd1;
    end
`else
    assign late_count = 16'h0;
`endif

endmodule

// File: tb/tb_my_tx_sched.sv
// Directed self-checking bench for my_tx_sched.
// Covers pass-through, timed release, late drop/send, wrap and reset.
module tb_my_tx_sched;

`ifdef TX_SCHED_LATE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam logic [7:0] SRB = 8'd136;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = 8'd0;
    logic [31:0] set_data = 32'd0;
    logic [31:0] mt = 32'd0;
    logic [31:0] rd_dat = 32'd0;
    logic [3:0]  rd_flags = 4'd0;
    logic        rd_rdy_i = 1'b0;
    logic        rd_rdy_o;
    logic [31:0] tx_dat;
    logic [3:0]  tx_flags;
    logic        tx_rdy_o;
    logic        tx_rdy_i = 1'b0;
    logic        late;
    logic [15:0] late_count;
    logic        busy;

    int checks = 0;
    int errors = 0;

    my_tx_sched dut (
        .clk(clk), .rst(rst),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .master_time(mt),
        .rd_dat_i(rd_dat), .rd_flags_i(rd_flags),
        .rd_ready_i(rd_rdy_i), .rd_ready_o(rd_rdy_o),
        .tx_dat_o(tx_dat), .tx_flags_o(tx_flags),
        .tx_ready_o(tx_rdy_o), .tx_ready_i(tx_rdy_i),
        .late(late), .late_count(late_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mt = mt + 32'd1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] v);
        tick();
        set_stb = 1'b1;
        set_addr = a;
        set_data = v;
        tick();
        set_stb = 1'b0;
    endtask

    // Prefix words; returns with the DUT entering WAIT on the next edge
    task automatic hdr_pkt(input logic im, input logic [31:0] st,
                           input logic [31:0] mt0);
        tick();
        mt = mt0;
        rd_dat = {16'hBEEF, 15'd0, im};
        rd_flags = 4'b0001;
        rd_rdy_i = 1'b1;
        tx_rdy_i = 1'b1;
        #1;
        check("hdr0_rdy", {31'd0, rd_rdy_o}, 32'd1);
        check("hdr0_txv", {31'd0, tx_rdy_o}, 32'd0);
        tick();
        rd_dat = st;
        rd_flags = 4'b0000;
        #1;
        check("hdr1_rdy", {31'd0, rd_rdy_o}, 32'd1);
        check("hdr1_txv", {31'd0, tx_rdy_o}, 32'd0);
    endtask

    // Payload source with tx backpressure pattern; checks order and stalls
    task automatic run_pay(input int n, input logic [31:0] base,
                           input logic [7:0] pat, output int stall,
                           output logic [31:0] mt_first,
                           output logic late_seen);
        int idx = 0;
        int cyc = 0;
        bit seen = 0;
        stall = 0;
        mt_first = 32'd0;
        late_seen = 1'b0;
        while (idx < n && cyc < 400) begin
            tick();
            rd_dat = base + idx;
            rd_flags = {2'b00, (idx == n - 1), 1'b0};
            rd_rdy_i = 1'b1;
            tx_rdy_i = pat[cyc % 8];
            #1;
            if (late) late_seen = 1'b1;
            if (tx_rdy_o && !seen) begin
                seen = 1;
                mt_first = mt;
            end
            if (!seen) stall++;
            if (tx_rdy_o && !tx_rdy_i)
                check("bp_hold", {31'd0, rd_rdy_o}, 32'd0);
            if (tx_rdy_o && tx_rdy_i) begin
                check("pay_dat", tx_dat, base + idx);
                idx++;
            end
            cyc++;
        end
        check("pay_cnt", idx, n);
        tick();
        rd_rdy_i = 1'b0;
        tx_rdy_i = 1'b1;
        #1;
        check("pay_idle", {31'd0, busy}, 32'd0);
    endtask

    int st;
    logic [31:0] mf;
    logic ls;

    initial begin
        #1;
        check("rst_rdo", {31'd0, rd_rdy_o}, 32'd0);
        check("rst_txv", {31'd0, tx_rdy_o}, 32'd0);
        check("rst_late", {31'd0, late}, 32'd0);
        check("rst_cnt", {16'd0, late_count}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        tick();
        rst = 1'b0;

        // enable=0: zero-latency wire pass-through
        for (int i = 0; i < 4; i++) begin
            tick();
            rd_dat = 32'hA000_0000 + i;
            rd_flags = {2'b00, (i == 3), (i == 0)};
            rd_rdy_i = 1'b1;
            tx_rdy_i = 1'b1;
            #1;
            check("t1_dat", tx_dat, 32'hA000_0000 + i);
            check("t1_flg", {28'd0, tx_flags},
                  {28'd0, 2'b00, (i == 3), (i == 0)});
            check("t1_txv", {31'd0, tx_rdy_o}, 32'd1);
            check("t1_rdo", {31'd0, rd_rdy_o}, 32'd1);
        end
        tick();
        rd_rdy_i = 1'b0;
        #1;
        check("t1_busy", {31'd0, busy}, 32'd0);

        // Timed release at 1000, from 900
        wr(SRB, 32'd1);
        hdr_pkt(1'b0, 32'd1000, 32'd900);
        run_pay(3, 32'hB000_0000, 8'hFF, st, mf, ls);
        check("t2_stall", st, 32'd99);
        check("t2_mt", mf, 32'd1001);
        check("t2_late", {31'd0, ls}, 32'd0);

        // Late packet, drop
        wr(SRB, 32'd3);
        hdr_pkt(1'b0, 32'd100, 32'd200);
        tick();
        rd_dat = 32'hC000_0000;
        rd_flags = 4'b0000;
        rd_rdy_i = 1'b1;
        #1;
        check("t3_wait_rdo", {31'd0, rd_rdy_o}, 32'd0);
        check("t3_late0", {31'd0, late}, 32'd0);
        tick();
        #1;
        check("t3_late1", {31'd0, late}, 32'd1);
        check("t3_cnt", {16'd0, late_count}, CNT_EN ? 32'd1 : 32'd0);
        check("t3_drop_txv", {31'd0, tx_rdy_o}, 32'd0);
        check("t3_drop_rdo", {31'd0, rd_rdy_o}, 32'd1);
        tick();
        rd_dat = 32'hC000_0001;
        rd_flags = 4'b0010;
        #1;
        check("t3_drop_txv2", {31'd0, tx_rdy_o}, 32'd0);
        check("t3_late_end", {31'd0, late}, 32'd0);
        tick();
        rd_dat = 32'h1234_5678;
        rd_flags = 4'b0011;
        #1;
        check("t3_next_txv", {31'd0, tx_rdy_o}, 32'd1);
        check("t3_next_dat", tx_dat, 32'h1234_5678);
        tick();
        rd_rdy_i = 1'b0;

        // Late packet, send at once
        wr(SRB, 32'd1);
        hdr_pkt(1'b0, 32'd100, 32'd200);
        run_pay(2, 32'hD000_0000, 8'hFF, st, mf, ls);
        check("t4_stall", st, 32'd1);
        check("t4_late", {31'd0, ls}, 32'd1);
        check("t4_cnt", {16'd0, late_count}, CNT_EN ? 32'd2 : 32'd0);

        // Clear register
        wr(SRB + 8'd1, 32'd0);
        #1;
        check("clr_cnt", {16'd0, late_count}, 32'd0);

        // Wrapping time, not late
        hdr_pkt(1'b0, 32'd5, 32'hFFFF_FFF0);
        run_pay(2, 32'hE000_0000, 8'hFF, st, mf, ls);
        check("t5_stall", st, 32'd20);
        check("t5_mt", mf, 32'd6);
        check("t5_late", {31'd0, ls}, 32'd0);

        // Async reset mid-PASS
        tick();
        rd_dat = 32'h0F00_0000;
        rd_flags = 4'b0001;
        rd_rdy_i = 1'b1;
        tx_rdy_i = 1'b1;
        tick();
        rd_dat = 32'h0F00_0001;
        rd_flags = 4'b0000;
        #1;
        check("t6_pass_txv", {31'd0, tx_rdy_o}, 32'd1);
        check("t6_busy", {31'd0, busy}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_txv", {31'd0, tx_rdy_o}, 32'd0);
        check("t6_rst_rdo", {31'd0, rd_rdy_o}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        tick();
        rst = 1'b0;
        rd_rdy_i = 1'b0;

        // Immediate packet from IDLE with toggling backpressure
        wr(SRB, 32'd1);
        hdr_pkt(1'b1, 32'h8000_0000, 32'd0);
        run_pay(4, 32'hF000_0000, 8'b1011_0010, st, mf, ls);
        check("t6_stall", st, 32'd1);
        check("t6_late", {31'd0, ls}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
